// File: rtl/crc_engine.sv
// crc_engine: serial MSB-first CRC generator/checker with a residue flag and
// step-handshaked serial output of the (optionally complemented) CRC.
module crc_engine #(
    parameter int unsigned      WIDTH      = 5,
    parameter logic [WIDTH-1:0] POLY       = 5'h09,
    parameter logic [WIDTH-1:0] INIT       = 5'h09,
    parameter logic [WIDTH-1:0] RESIDUE    = 5'h00,
    parameter bit               OUT_INVERT = 1'b0,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             crcinclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             crcbitin,
    input  logic             out_start,
    input  logic             out_step,
    output logic [WIDTH-1:0] crc,
    output logic             crc_ok,
    output logic [CNT_W-1:0] bitcount,
    output logic             crcbitout,
    output logic             out_valid,
    output logic             out_done
);

    localparam int unsigned         SCNT_W    = $clog2(WIDTH + 1);
    localparam logic [SCNT_W-1:0]   SCNT_LAST = SCNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    OUT_MASK  = {WIDTH{OUT_INVERT}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   bitcount_q, bitcount_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               out_valid_q, out_valid_d;
    logic               out_done_q, out_done_d;
    logic [WIDTH-1:0]   fold_s;

    function automatic logic [WIDTH-1:0] crc_fold(input logic [WIDTH-1:0] cur,
                                                  input logic din);
        logic fb;
        fb = din ^ cur[WIDTH-1];
        return {cur[WIDTH-2:0], 1'b0} ^ (fb ? POLY : {WIDTH{1'b0}});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign fold_s = crc_fold(crc_q, crcbitin);

    // Next-state logic; start overrides everything, and a bit folded on the
    // out_start edge is included in the value loaded for serial output.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        bitcount_d  = bitcount_q;
        sreg_d      = sreg_q;
        scnt_d      = scnt_q;
        out_valid_d = out_valid_q;
        out_done_d  = 1'b0;
        if (start) begin
            crc_d       = bit_valid ? crc_fold(INIT, crcbitin) : INIT;
            bitcount_d  = {{(CNT_W-1){1'b0}}, bit_valid};
            sreg_d      = {WIDTH{1'b0}};
            scnt_d      = {SCNT_W{1'b0}};
            out_valid_d = 1'b0;
            state_d     = bit_valid ? ST_ACCUM : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (bit_valid) begin
                        crc_d      = fold_s;
                        bitcount_d = sat_inc(bitcount_q);
                        state_d    = ST_ACCUM;
                    end else begin
                        state_d    = state_q;
                    end
                    if (out_start) begin
                        sreg_d      = crc_d ^ OUT_MASK;
                        scnt_d      = {SCNT_W{1'b0}};
                        out_valid_d = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (out_step && out_valid_q) begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                        scnt_d = scnt_q + {{(SCNT_W-1){1'b0}}, 1'b1};
                        if (scnt_q == SCNT_LAST) begin
                            out_valid_d = 1'b0;
                            out_done_d  = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            out_valid_d = 1'b1;
                        end
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge crcinclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            bitcount_q  <= {CNT_W{1'b0}};
            sreg_q      <= {WIDTH{1'b0}};
            scnt_q      <= {SCNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            bitcount_q  <= bitcount_d;
            sreg_q      <= sreg_d;
            scnt_q      <= scnt_d;
            out_valid_q <= out_valid_d;
            out_done_q  <= out_done_d;
        end
    end

    assign crc       = crc_q;
    assign crc_ok    = (crc_q == RESIDUE);
    assign bitcount  = bitcount_q;
    assign crcbitout = sreg_q[WIDTH-1];
    assign out_valid = out_valid_q;
    assign out_done  = out_done_q;

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: randomized self-checking bench for crc_engine using a
// polynomial long-division reference model over the folded message.
module tb_crc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, bit_valid, crcbitin, out_start, out_step;
    logic [4:0]  crc5, crc5s;
    logic [15:0] crc16;
    logic        ok5, ok16, ok5s;
    logic [15:0] bc5, bc16;
    logic [2:0]  bc5s;
    logic        bo5, bo16, bo5s, ov5, ov16, ov5s, od5, od16, od5s;

    int n_cmp = 0;
    int n_err = 0;
    bit msg[$];

    crc_engine dut5 (
        .crcinclk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .crcbitin(crcbitin), .out_start(out_start), .out_step(out_step),
        .crc(crc5), .crc_ok(ok5), .bitcount(bc5), .crcbitout(bo5),
        .out_valid(ov5), .out_done(od5));

    crc_engine #(.WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .RESIDUE(16'h1D0F),
                 .OUT_INVERT(1'b1)) dut16 (
        .crcinclk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .crcbitin(crcbitin), .out_start(out_start), .out_step(out_step),
        .crc(crc16), .crc_ok(ok16), .bitcount(bc16), .crcbitout(bo16),
        .out_valid(ov16), .out_done(od16));

    crc_engine #(.CNT_W(3)) dut5s (
        .crcinclk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .crcbitin(crcbitin), .out_start(out_start), .out_step(out_step),
        .crc(crc5s), .crc_ok(ok5s), .bitcount(bc5s), .crcbitout(bo5s),
        .out_valid(ov5s), .out_done(od5s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (M(x)*x^w + INIT*x^n) mod (x^w + poly).
    function automatic logic [15:0] ref_crc(input int w, input logic [15:0] poly,
                                            input logic [15:0] init);
        bit a[$];
        int n;
        logic [15:0] r;
        a = msg;
        n = msg.size();
        for (int j = 0; j < w; j++) a.push_back(1'b0);
        for (int j = 0; j < w; j++) a[j] = a[j] ^ init[w-1-j];
        for (int i = 0; i < n; i++) begin
            if (a[i]) begin
                a[i] = 1'b0;
                for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
            end
        end
        r = 16'h0000;
        for (int j = 0; j < w; j++) r[w-1-j] = a[n+j];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fold(input logic b);
        bit_valid = 1'b1;
        crcbitin  = b;
        step();
        bit_valid = 1'b0;
        msg.push_back(b);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        msg.delete();
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e5, e16;
        int n;
        e5  = ref_crc(5, 16'h0009, 16'h0009);
        e16 = ref_crc(16, 16'h1021, 16'hFFFF);
        n   = msg.size();
        chk({tag, "_crc5"},  32'(crc5),  32'(e5[4:0]));
        chk({tag, "_crc16"}, 32'(crc16), 32'(e16));
        chk({tag, "_crc5s"}, 32'(crc5s), 32'(e5[4:0]));
        chk({tag, "_ok5"},   32'(ok5),   32'(e5[4:0] == 5'h00));
        chk({tag, "_ok16"},  32'(ok16),  32'(e16 == 16'h1D0F));
        chk({tag, "_bc5"},   32'(bc5),   32'(n));
        chk({tag, "_bc16"},  32'(bc16),  32'(n));
        chk({tag, "_bc5s"},  32'(bc5s),  32'((n > 7) ? 7 : n));
    endtask

    task automatic run_shift(input int maxgap, input bit noise, input bit fold_with_start,
                             output logic [15:0] w16);
        logic [15:0] e16, r;
        logic [4:0]  e5;
        int s, guard, gap;
        bit took, b;
        if (fold_with_start) begin
            b = 1'($urandom % 2);
            bit_valid = 1'b1;
            crcbitin  = b;
            msg.push_back(b);
        end
        r   = ref_crc(5, 16'h0009, 16'h0009);
        e5  = r[4:0];
        e16 = ~ref_crc(16, 16'h1021, 16'hFFFF);
        out_start = 1'b1;
        out_step  = (maxgap == 0);
        step();
        out_start = 1'b0;
        bit_valid = 1'b0;
        took  = 1'b0;
        s     = 0;
        guard = 0;
        gap   = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
        w16   = 16'h0000;
        while (1) begin
            chk("sh_valid16", 32'(ov16), 32'(s < 16));
            if (s < 16) begin
                chk("sh_bit16", 32'(bo16), 32'(e16[15-s]));
                w16[15-s] = bo16;
            end
            chk("sh_done16", 32'(od16), 32'(took && s == 16));
            chk("sh_valid5", 32'(ov5), 32'(s < 5));
            if (s < 5) chk("sh_bit5", 32'(bo5), 32'(e5[4-s]));
            chk("sh_done5", 32'(od5), 32'(took && s == 5));
            if (s == 16) break;
            guard++;
            if (guard > 300) begin
                chk("sh_timeout", 32'(s), 32'd16);
                break;
            end
            if (gap == 0) begin
                out_step = 1'b1;
                gap = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
            end else begin
                out_step = 1'b0;
                gap--;
            end
            if (noise && s < 5) begin
                bit_valid = 1'($urandom % 2);
                crcbitin  = 1'($urandom % 2);
            end else begin
                bit_valid = 1'b0;
            end
            step();
            took = out_step;
            if (took) s++;
        end
        out_step  = 1'b0;
        bit_valid = 1'b0;
        step();
        chk("post_done16", 32'(od16), 32'd0);
        chk("post_done5",  32'(od5),  32'd0);
        chk("post_valid16", 32'(ov16), 32'd0);
        check_all("post_shift");
    endtask

    task automatic shift_seven();
        do_start();
        for (int i = 0; i < 10; i++) fold(1'($urandom % 2));
        out_start = 1'b1;
        out_step  = 1'b1;
        step();
        out_start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        out_step = 1'b0;
        chk("abort_pre_valid16", 32'(ov16), 32'd1);
    endtask

    task automatic fold_string(input string str);
        logic [7:0] ch;
        for (int i = 0; i < str.len(); i++) begin
            ch = str[i];
            for (int b = 7; b >= 0; b--) fold(ch[b]);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] tail;
        reset_n = 1'b0; start = 1'b0; bit_valid = 1'b0; crcbitin = 1'b0;
        out_start = 1'b0; out_step = 1'b0;
        step();
        step();
        chk("rst_crc5",  32'(crc5),  32'h09);
        chk("rst_ok5",   32'(ok5),   32'd0);
        chk("rst_bc5",   32'(bc5),   32'd0);
        chk("rst_ov5",   32'(ov5),   32'd0);
        chk("rst_crc16", 32'(crc16), 32'hFFFF);
        #3 reset_n = 1'b1;
        step();

        // Gen2 CRC-5 residue check
        fold(1'b0); fold(1'b1); fold(1'b0); fold(1'b0); fold(1'b1);
        chk("c5_crc", 32'(crc5), 32'h00);
        chk("c5_ok",  32'(ok5),  32'd1);
        chk("c5_bc",  32'(bc5),  32'd5);
        check_all("c5");
        fold(1'b1); fold(1'b0); fold(1'b1);
        check_all("sat");

        // start together with bit_valid
        start = 1'b1; bit_valid = 1'b1; crcbitin = 1'b1;
        step();
        start = 1'b0; bit_valid = 1'b0;
        msg.delete(); msg.push_back(1'b1);
        chk("sbv_crc5", 32'(crc5), 32'h1B);
        chk("sbv_bc5",  32'(bc5),  32'd1);
        check_all("sbv");

        // CRC-16 check string and its transmit
        do_start();
        fold_string("123456789");
        chk("chk_crc16", 32'(crc16), 32'h29B1);
        chk("chk_bc16",  32'(bc16),  32'd72);
        check_all("chk");
        run_shift(0, 1'b0, 1'b0, w);
        chk("tx_word16", 32'(w), 32'hD64E);

        do_start();
        fold_string("123456789");
        tail = 16'hD64E;
        for (int b = 15; b >= 0; b--) fold(tail[b]);
        chk("res_crc16", 32'(crc16), 32'h1D0F);
        chk("res_ok16",  32'(ok16),  32'd1);
        chk("res_bc16",  32'(bc16),  32'd88);

        // randomized folds with irregular serial output
        for (int r = 0; r < 8; r++) begin
            do_start();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
                if ($urandom % 3 == 0) step();
                fold(1'($urandom % 2));
            end
            check_all("rnd");
            run_shift(3, 1'b1, 1'($urandom % 2), w);
        end

        // mid-shift abort by start
        shift_seven();
        start = 1'b1;
        step();
        start = 1'b0;
        msg.delete();
        chk("ab_valid16", 32'(ov16), 32'd0);
        chk("ab_done16",  32'(od16), 32'd0);
        chk("ab_crc16",   32'(crc16), 32'hFFFF);
        chk("ab_bc16",    32'(bc16), 32'd0);
        step();
        chk("ab_done16_b", 32'(od16), 32'd0);
        check_all("ab");

        // mid-shift abort by asynchronous reset
        shift_seven();
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid16", 32'(ov16), 32'd0);
        chk("ar_bit16",   32'(bo16), 32'd0);
        chk("ar_done16",  32'(od16), 32'd0);
        chk("ar_crc16",   32'(crc16), 32'hFFFF);
        chk("ar_bc16",    32'(bc16), 32'd0);
        chk("ar_crc5",    32'(crc5), 32'h09);
        #1 reset_n = 1'b1;
        msg.delete();
        step();
        chk("ar_done16_b", 32'(od16), 32'd0);
        check_all("ar");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
- Parametrised serial CRC generator/checker for the tag datapath, covering Gen2 CRC-5 (query) and CRC-16 (command check, reply generation).
- Folds one bit per qualified clock into a WIDTH-bit LFSR, MSB-first.
- Flags a residue match for receive-side checking.
- Serialises the (optionally complemented) CRC MSB-first for transmit through a step handshake.

Parameters:
- WIDTH, 5, CRC register width (5 or 16 used; any value ≥ 2 is legal).
- POLY, 5'h09, generator polynomial without the x^WIDTH term (CRC-16: 16'h1021).
- INIT, 5'h09, preset value loaded on reset and on start (CRC-16: 16'hFFFF).
- RESIDUE, 5'h00, good-check residue value (CRC-16: 16'h1D0F).
- OUT_INVERT, 0, 1 = complement the CRC before serial output (CRC-16 transmit).
- CNT_W, 16, width of the bit counter.

Ports:
- crcinclk  in  1  the single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous re-preset to INIT and clear of the counter; aborts any transfer.
- bit_valid  in  1  fold crcbitin on this edge.
- crcbitin  in  1  serial data bit, MSB-first.
- out_start  in  1  begin serial output of the current CRC.
- out_step  in  1  consumer has taken crcbitout; advance to the next bit.
- crc  out  WIDTH  current CRC register.
- crc_ok  out  1  combinational: crc == RESIDUE.
- bitcount  out  CNT_W  bits folded since last start/reset; saturates at all-ones.
- crcbitout  out  1  current serial output bit.
- out_valid  out  1  high while crcbitout is meaningful.
- out_done  out  1  one-cycle pulse after the last bit is taken.

Behaviour:
- Async reset (reset_n low):
  - crc=INIT, bitcount=0, state=IDLE.
  - Shift register=0, counter=0.
  - crcbitout=0, out_valid=0, out_done=0.
- Update function:
  - fb = crcbitin ^ crc[WIDTH-1].
  - crc_next = {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- States: IDLE, ACCUM, SHIFT.
- IDLE:
  - bit_valid → crc = update(crc), bitcount+1, go to ACCUM.
  - out_start → go to SHIFT.
- ACCUM:
  - bit_valid folds as in IDLE.
  - out_start → go to SHIFT.
  - If bit_valid and out_start are both high, the bit is folded first. The shift register loads the post-fold CRC.
- Entering SHIFT:
  - Shift register = crc (complemented if OUT_INVERT); shift counter = 0.
  - crc itself is unchanged.
- SHIFT:
  - out_valid = 1; crcbitout = shift register MSB.
  - out_step → shift left by 1, counter+1.
  - On the WIDTH-th out_step: out_valid drops next cycle, out_done pulses for one cycle, return to IDLE.
  - out_step with out_valid low is ignored.
  - bit_valid and out_start are ignored.
- start, any state, highest priority:
  - crc = INIT, bitcount = 0, shift counter = 0, out_valid = 0, no out_done.
  - Next state is IDLE; if bit_valid is also high, next state is ACCUM.
  - start together with bit_valid: crc = update(INIT, crcbitin), bitcount = 1.
- Latency:
  - crc and bitcount reflect a folded bit one cycle after its edge.
  - crc_ok has no added latency over crc.
  - First crcbitout is valid the cycle after out_start.
- bitcount saturates at 2^CNT_W-1. crc keeps updating after saturation.
- reset_n asserted mid-SHIFT: output aborts immediately, out_done is not pulsed.

Test Plan:
- Reset → crc=5'b01001, crc_ok=0, bitcount=0, out_valid=0. Default params: fold 0,1,0,0,1 → crc=5'b00000, crc_ok=1, bitcount=5.
- Default params: start and bit_valid with crcbitin=1 on the same edge → crc=5'b11011, bitcount=1.
- CRC-16 params (WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, RESIDUE=16'h1D0F, OUT_INVERT=1):
  - Fold ASCII "123456789" MSB-first → crc=16'h29B1, bitcount=72.
  - Then out_start with out_step held high → crcbitout sequence 1101_0110_0100_1110 (16'hD64E); out_done pulses once, 16 cycles after the first valid bit.
  - Start, fold "123456789" followed by the 16 bits of 16'hD64E → crc=16'h1D0F, crc_ok=1, bitcount=88.
- SHIFT with irregular out_step (gaps of 0–3 cycles) → crcbitout holds between steps; exactly WIDTH bits are emitted; bit_valid pulses during SHIFT leave crc and bitcount unchanged.
- Mid-SHIFT abort:
  - After 7 bits, start → out_valid=0 next cycle, no out_done, crc=INIT.
  - Repeat with reset_n pulsed low instead → all outputs at reset values asynchronously.
